// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I width codes, FSM state encodings
// and the funct3 legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t IDLE    = 3'd0;
    localparam lsu_state_t RD      = 3'd1;
    localparam lsu_state_t RD_WAIT = 3'd2;
    localparam lsu_state_t WR      = 3'd3;
    localparam lsu_state_t RESP    = 3'd4;

    // Stores only have B/H/W; loads additionally have the unsigned BU/HU forms.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
        else
            return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                     (f3 == F3_BU) || (f3 == F3_HU));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a RAM word, and merges
// byte/half store data into a read word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_ea_lo,
    input  logic [XLEN-1:0] i_word,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_load_data,
    output logic [XLEN-1:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_ea_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_ea_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_load_data = i_word;
        case (i_funct3)
            F3_B:    o_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_load_data = i_word;
        endcase
    end

    always_comb begin
        o_store_word = i_word;
        case (i_funct3)
            F3_B:    o_store_word[{i_ea_lo, 3'b000} +: 8]     = i_wdata[7:0];
            F3_H:    o_store_word[{i_ea_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_store_word = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a 1-cycle registered-read word RAM; byte/half stores use RMW.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning.
//
// state   | meaning
// IDLE    | ready for a request, no RAM strobes
// RD      | mem_re asserted for the latched word
// RD_WAIT | RAM data present: extract load result or merge store lane
// WR      | mem_we asserted for one cycle
// RESP    | rsp_valid held until rsp_ready
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int XLEN   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_is_store,
    input  logic [2:0]        i_req_funct3,
    input  logic [XLEN-1:0]   i_req_rs1,
    input  logic [XLEN-1:0]   i_req_imm,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [XLEN-1:0]   o_rsp_data,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    lsu_state_t        r_state;
    logic [2:0]        r_funct3;
    logic              r_is_store;
    logic [1:0]        r_ea_lo;
    logic [XLEN-1:0]   r_wdata;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [XLEN-1:0]   r_rsp_data;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [XLEN-1:0]   r_mem_wdata;

    logic [XLEN-1:0]   w_ea;
    logic [XLEN-1:0]   w_ea_fixed;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_illegal;
    logic              w_misalign;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_store_word;
    logic              w_unused_ea;

    assign w_ea      = i_req_rs1 + i_req_imm;
    assign w_is_half = (i_req_funct3[1:0] == 2'b01);
    assign w_is_word = (i_req_funct3 == F3_W);
    assign w_illegal = f3_illegal(i_req_is_store, i_req_funct3);

    always_comb begin
        w_ea_fixed = w_ea;
        w_misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = (w_is_half && w_ea[0]) || (w_is_word && (w_ea[1:0] != 2'b00));
`else
        if (w_is_half)
            w_ea_fixed[0] = 1'b0;
        if (w_is_word)
            w_ea_fixed[1:0] = 2'b00;
`endif
    end

    // Byte-address bits above the RAM word index are dropped so addresses wrap.
    assign w_unused_ea = ^w_ea_fixed[XLEN-1:ADDR_W+2];

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_funct3     (r_funct3),
        .i_ea_lo      (r_ea_lo),
        .i_word       (i_mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_funct3    <= F3_B;
            r_is_store  <= 1'b0;
            r_ea_lo     <= 2'b00;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_mem_addr  <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_funct3   <= i_req_funct3;
                        r_is_store <= i_req_is_store;
                        r_ea_lo    <= w_ea_fixed[1:0];
                        r_wdata    <= i_req_wdata;
                        r_mem_addr <= w_ea_fixed[ADDR_W+1:2];
                        if (w_illegal || w_misalign) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else if (i_req_is_store && w_is_word) begin
                            r_mem_wdata <= i_req_wdata;
                            r_mem_we    <= 1'b1;
                            r_state     <= WR;
                        end else begin
                            r_mem_re <= 1'b1;
                            r_state  <= RD;
                        end
                    end
                end
                RD: begin
                    r_mem_re <= 1'b0;
                    r_state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (r_is_store) begin
                        r_mem_wdata <= w_store_word;
                        r_mem_we    <= 1'b1;
                        r_state     <= WR;
                    end else begin
                        r_rsp_data  <= w_load_data;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                WR: begin
                    r_mem_we    <= 1'b0;
                    r_rsp_data  <= '0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_mem_re    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_data  = r_rsp_data;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_re    = r_mem_re;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly upstream of the single-cycle data RAM (32 x 32-bit words, registered read, 1-cycle latency).
- Accepts one memory request from the execute stage and computes the effective address.
- Drives word-granular RAM read/write strobes and performs read-modify-write (RMW) for byte/half stores.
- Returns sign- or zero-extended load data to write-back over a valid/ready response handshake.

Parameters:
- ADDR_W, 5, RAM word-index width. Byte address bits [ADDR_W+1:2] select the word; higher bits are dropped, so addresses wrap.
- XLEN, 32, data and address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_rs1  in  XLEN  base address
- req_imm  in  XLEN  offset, already sign-extended
- req_wdata  in  XLEN  store data (rs2)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  XLEN  load result; 0 for stores
- rsp_err  out  1  illegal funct3 or misaligned access (trap)
- mem_addr  out  ADDR_W  RAM word index
- mem_re  out  1  RAM read strobe; data valid the following cycle
- mem_we  out  1  RAM write strobe; word written at the clock edge
- mem_wdata  out  XLEN  RAM write word
- mem_rdata  in  XLEN  RAM registered read data

Behaviour:
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- A reset asserted mid-operation aborts immediately; mem_we drops asynchronously and no partial write completes after reset.
- Effective address: ea = rs1 + imm, modulo 2^XLEN.
- On acceptance (req_valid & req_ready), latch ea, funct3, is_store and wdata.
- mem_re and mem_we are registered outputs, never high together, and both are 0 outside RD/WR.
- States: IDLE, RD, RD_WAIT, WR, RESP.
- IDLE -> RD: load, or store of B/H.
- IDLE -> WR: SW.
- IDLE -> RESP with rsp_err=1 and no memory access: illegal funct3. Illegal codes are 011/110/111 for loads and anything other than 000/001/010 for stores.
- RD: mem_re=1, mem_addr=ea word index.
- RD_WAIT, load: extract lane by ea[1:0] (B) or ea[1] (H), extend by funct3, register into rsp_data, go to RESP.
- RD_WAIT, store: merge req_wdata[7:0] or [15:0] into the read word at the addressed lane, register into mem_wdata, go to WR.
- WR: mem_we=1 for exactly one cycle, then RESP.
- RESP: rsp_valid=1, holding rsp_data and rsp_err stable until rsp_ready; on handshake go to IDLE.
- rsp_valid rises this many cycles after acceptance:
  - load: 3
  - SW: 2
  - SB/SH: 4
  - error: 1
- Throughput: one request in flight. A new request can be accepted the cycle after the response handshake.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - H/HU/SH with ea[0]=1 is misaligned.
  - W/SW with ea[1:0]!=0 is misaligned.
  - Misaligned requests go IDLE -> RESP with rsp_err=1, rsp_data=0, and no RAM strobe.
- LSU_MISALIGN_TRAP_EN undefined: ea is force-aligned (bit 0 cleared for H, bits [1:0] for W), the access proceeds normally, and rsp_err is set only for illegal funct3.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum (IDLE, RD, RD_WAIT, WR, RESP).
- Sub-module lsu_align (purely combinational): load lane extract/extend and store lane merge, given funct3, ea[1:0], word and store data.

Test Plan:
1. SW rs1=0x10, imm=0x4, wdata=0xDEADBEEF; then LW at 0x14 -> mem_we pulse with mem_addr=5; load rsp_data=0xDEADBEEF, rsp_valid 3 cycles after acceptance, rsp_err=0.
2. Word 5=0xDEADBEEF; SB at ea=0x15, wdata=0x11 -> RD then WR with mem_wdata=0xDEAD11EF; a following LB at 0x17 -> rsp_data=0xFFFFFFDE, LBU at 0x17 -> 0x000000DE.
3. LH at 0x16 on 0xDEAD11EF -> 0xFFFFDEAD; LHU -> 0x0000DEAD.
4. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0, no mem strobes; release -> IDLE next cycle.
5. Load with funct3=011 -> rsp_err=1 one cycle after acceptance, with no mem_re or mem_we.
6. Assert rst during WR of an SB -> mem_we=0 immediately, outputs at reset values, req_ready=1. LW at 0x16: with LSU_MISALIGN_TRAP_EN -> rsp_err=1; without -> reads word 5.
